if_id_stage: RTL and testbench

- Fetch-to-decode pipeline register that sits directly downstream of the PC block and instruction memory.
- Captures the fetched instruction together with its PC, fetch-exception code and branch-delay-slot flag, and presents them to the D stage.
- Implements stall hold, interrupt/exception flush, and delay-slot tracking for the P7 exception pipeline.

---
 rtl/mips_defs.sv | 22 ++
 rtl/bd_detect.sv | 27 ++
 rtl/if_id_stage.sv | 64 ++++++
 tb/tb_if_id_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS encodings, exception codes and fixed PCs used by the fetch/decode pipeline.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] EXC_NONE   = 5'd0;
  localparam logic [4:0] EXC_ADEL   = 5'd4;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/bd_detect.sv
// Flags branch and jump instructions, i.e. those whose successor sits in a delay slot.
module bd_detect
  import mips_defs::*;
(
  input  logic [31:0] instr,
  output logic        is_bj
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign unused_bits = ^instr[25:6];

  always_comb begin
    is_bj = 1'b0;
    unique case (opcode)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_REGIMM, OP_J, OP_JAL:           is_bj = 1'b1;
      OP_SPECIAL:                        is_bj = (funct == FN_JR) || (funct == FN_JALR);
      default:                           is_bj = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// F-to-D pipeline register with stall hold, exception flush and branch-delay-slot tracking.
module if_id_stage
  import mips_defs::*;
#(
  parameter logic [31:0] EXC_HANDLER = HANDLER_PC,
  parameter logic [4:0]  EXC_ADEL    = mips_defs::EXC_ADEL,
  parameter logic [4:0]  EXC_NONE    = mips_defs::EXC_NONE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_F,
  input  logic [31:0] instr_F,
  input  logic        adel_F,
  input  logic        stall,
  input  logic        req,
  output logic [31:0] pc_D,
  output logic [31:0] instr_D,
  output logic [4:0]  exc_D,
  output logic        bd_D,
  output logic        valid_D
);

  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [4:0]  exc_reg;
  logic        bd_reg;
  logic        valid_reg;
  logic        d_is_bj;

  // Examines the instruction currently held in D, so its successor gets the delay-slot flag.
  bd_detect u_bd_detect (
    .instr (instr_reg),
    .is_bj (d_is_bj)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg    <= RESET_PC;
      instr_reg <= 32'h0;
      exc_reg   <= EXC_NONE;
      bd_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else if (req) begin
      pc_reg    <= EXC_HANDLER;
      instr_reg <= 32'h0;
      exc_reg   <= EXC_NONE;
      bd_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else if (!stall) begin
      pc_reg    <= pc_F;
      instr_reg <= adel_F ? 32'h0 : instr_F;
      exc_reg   <= adel_F ? EXC_ADEL : EXC_NONE;
      bd_reg    <= d_is_bj && valid_reg;
      valid_reg <= 1'b1;
    end
  end

  assign pc_D    = pc_reg;
  assign instr_D = instr_reg;
  assign exc_D   = exc_reg;
  assign bd_D    = bd_reg;
  assign valid_D = valid_reg;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for the F-to-D pipeline register.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset;
  logic [31:0] pc_F;
  logic [31:0] instr_F;
  logic        adel_F;
  logic        stall;
  logic        req;
  logic [31:0] pc_D;
  logic [31:0] instr_D;
  logic [4:0]  exc_D;
  logic        bd_D;
  logic        valid_D;
  logic [70:0] obs;
  logic [70:0] exp_v;

  int tests = 0;
  int fails = 0;

  if_id_stage dut (
    .clk     (clk),
    .reset   (reset),
    .pc_F    (pc_F),
    .instr_F (instr_F),
    .adel_F  (adel_F),
    .stall   (stall),
    .req     (req),
    .pc_D    (pc_D),
    .instr_D (instr_D),
    .exc_D   (exc_D),
    .bd_D    (bd_D),
    .valid_D (valid_D)
  );

  always #5 if (clk_en) clk = ~clk;

  // Observed D-stage state as {pc, instr, exc, bd, valid}.
  assign obs = {pc_D, instr_D, exc_D, bd_D, valid_D};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got tests=%0d required finish", tests);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
    $display("[TB] edge pc_D=%h instr_D=%h exc_D=%0d bd_D=%0b valid_D=%0b", pc_D, instr_D, exc_D, bd_D, valid_D);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic adel);
    pc_F    = pc;
    instr_F = ins;
    adel_F  = adel;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; req = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    #5 reset = 1'b0;
    #1;
    exp_v = {32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL reset_async: got %h required %h", obs, exp_v);
    end
    clk_en = 1'b1;
    reset  = 1'b1;
    drive(32'h3000, 32'h3c01_1234, 1'b0);
    step();
    exp_v = {32'h0000_3000, 32'h3c01_1234, 5'd0, 1'b0, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL first_load: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_branch();
    drive(32'h3004, 32'h1022_0003, 1'b0);
    step();
    exp_v = {32'h0000_3004, 32'h1022_0003, 5'd0, 1'b0, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL beq_load: got %h required %h", obs, exp_v);
    end
    drive(32'h3008, 32'h0, 1'b0);
    step();
    exp_v = {32'h0000_3008, 32'h0, 5'd0, 1'b1, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL delay_slot: got %h required %h", obs, exp_v);
    end
    drive(32'h300c, 32'h0, 1'b0);
    step();
    exp_v = {32'h0000_300c, 32'h0, 5'd0, 1'b0, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL after_slot: got %h required %h", obs, exp_v);
    end
  endtask

  // Each encoding is loaded, followed by a nop whose bd_D must match the branch/jump class.
  task automatic test_decode_table();
    logic [31:0] ins_tab [12];
    logic        bj_tab  [12];
    ins_tab = '{32'h1022_0003, 32'h1422_0003, 32'h1840_0002, 32'h1c40_0002,
                32'h0440_0002, 32'h0441_0002, 32'h0800_0c00, 32'h0c00_0c00,
                32'h03e0_0008, 32'h0040_f809, 32'h4200_0018, 32'h0022_180a};
    bj_tab  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      drive(32'h3100 + 32'(i * 8), ins_tab[i], 1'b0);
      step();
      drive(32'h3104 + 32'(i * 8), 32'h0, 1'b0);
      step();
      exp_v = {32'h3104 + 32'(i * 8), 32'h0, 5'd0, bj_tab[i], 1'b1};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL decode_%0d instr=%h: got %h required %h", i, ins_tab[i], obs, exp_v);
      end
    end
  endtask

  task automatic test_adel();
    drive(32'h3002, 32'h8c01_0000, 1'b1);
    step();
    exp_v = {32'h0000_3002, 32'h0, 5'd4, 1'b0, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL adel_load: got %h required %h", obs, exp_v);
    end
    drive(32'h3200, 32'h1022_0003, 1'b0);
    step();
    drive(32'h3205, 32'h1022_0003, 1'b1);
    step();
    exp_v = {32'h0000_3205, 32'h0, 5'd4, 1'b1, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL adel_in_slot: got %h required %h", obs, exp_v);
    end
    drive(32'h3208, 32'h0, 1'b0);
    step();
    exp_v = {32'h0000_3208, 32'h0, 5'd0, 1'b0, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL adel_no_mark: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_stall();
    drive(32'h3010, 32'h1022_0003, 1'b0);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h3014 + 32'(i * 4), 32'h2401_0000 + 32'(i), 1'b0);
      step();
      exp_v = {32'h0000_3010, 32'h1022_0003, 5'd0, 1'b0, 1'b1};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL stall_hold_%0d: got %h required %h", i, obs, exp_v);
      end
    end
    stall = 1'b0;
    drive(32'h3020, 32'h2402_0005, 1'b0);
    step();
    exp_v = {32'h0000_3020, 32'h2402_0005, 5'd0, 1'b1, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL stall_release: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_flush();
    drive(32'h3030, 32'h0c00_0c00, 1'b0);
    step();
    stall = 1'b1;
    req   = 1'b1;
    drive(32'h3034, 32'h2403_0001, 1'b0);
    step();
    exp_v = {32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL flush_over_stall: got %h required %h", obs, exp_v);
    end
    stall = 1'b0;
    req   = 1'b0;
    drive(32'h4180, 32'h0, 1'b0);
    step();
    exp_v = {32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL after_flush: got %h required %h", obs, exp_v);
    end
    drive(32'h3041, 32'h0, 1'b1);
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    exp_v = {32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL flush_clears_exc: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    drive(32'h3050, 32'h1422_0003, 1'b0);
    step();
    stall = 1'b1;
    #2 reset = 1'b0;
    #1;
    exp_v = {32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL reset_mid_stall: got %h required %h", obs, exp_v);
    end
    #1 reset = 1'b1;
    stall = 1'b0;
    drive(32'h3000, 32'h0, 1'b0);
    step();
    exp_v = {32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL load_after_reset: got %h required %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_decode_table();
    test_adel();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
